// File: rtl/i2c_master_pkg.sv
// Shared definitions for the single-byte I2C master: FSM encoding, quarter-phase
// names, bit counter width and the prescaler divisor limits.
package i2c_master_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_ACK_A,
    ST_WR_DATA,
    ST_ACK_W,
    ST_RD_DATA,
    ST_MNACK,
    ST_STOP
  } state_t;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  localparam int BIT_CNT_W   = 3;
  localparam int CLK_DIV_MIN = 4;
  localparam int CLK_DIV_MAX = 65535;

  // Below the minimum the 2-FF SDA synchroniser no longer settles inside q2.
  function automatic int legal_div(input int div);
    if (div < CLK_DIV_MIN) return CLK_DIV_MIN;
    if (div > CLK_DIV_MAX) return CLK_DIV_MAX;
    return div;
  endfunction

endpackage

// File: rtl/i2c_quarter_tick.sv
// Prescaler producing a one-cycle tick every CLK_DIV clocks while enabled;
// restart forces the count back to zero so the first quarter is full length.
module i2c_quarter_tick
  import i2c_master_pkg::*;
#(
  parameter int CLK_DIV = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic restart,
  output logic tick
);

  localparam int         DIV  = legal_div(CLK_DIV);
  localparam logic [15:0] LAST = 16'(DIV - 1);

  logic [15:0] cnt_reg;

  assign tick = en && (cnt_reg == LAST);

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= (cnt_reg == LAST) ? 16'd0 : cnt_reg + 16'd1;
    end
  end

endmodule

// File: rtl/i2c_master_byte.sv
// Single-byte I2C master: START, 7-bit address + R/W, one data byte (write or
// read), ACK/NACK, STOP. Open-drain SCL/SDA, no clock stretching.
module i2c_master_byte
  import i2c_master_pkg::*;
#(
  parameter int CLK_DIV = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] adr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic       nack,
  output wire        SCL,
  inout  wire        SDA
);

  state_t               state_reg, state_next;
  logic [1:0]           quarter_reg, quarter_next;
  logic [BIT_CNT_W-1:0] bit_cnt_reg, bit_cnt_next;
  logic [7:0]           shift_reg, shift_next;
  logic [7:0]           rx_reg, rx_next;
  logic [7:0]           rdata_reg, rdata_next;
  logic [7:0]           wdata_reg, wdata_next;
  logic                 rw_reg, rw_next;
  logic                 nack_reg, nack_next;
  logic                 done_reg, done_next;
  logic                 sample_reg, sample_next;
  logic                 scl_low_reg, scl_low_next;
  logic                 sda_low_reg, sda_low_next;
  logic                 sda_meta_reg, sda_sync_reg;
  logic                 accept;
  logic                 last_bit;
  logic                 tick;

  i2c_quarter_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk     (clk),
    .reset   (reset),
    .en      (state_reg != ST_IDLE),
    .restart (accept),
    .tick    (tick)
  );

  // Line drivers are registered so the pins never glitch between quarters.
  assign SCL   = scl_low_reg ? 1'b0 : 1'bz;
  assign SDA   = sda_low_reg ? 1'b0 : 1'bz;
  assign busy  = (state_reg != ST_IDLE);
  assign done  = done_reg;
  assign nack  = nack_reg;
  assign rdata = rdata_reg;

  always_comb begin
    state_next   = state_reg;
    quarter_next = quarter_reg;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    rx_next      = rx_reg;
    rdata_next   = rdata_reg;
    wdata_next   = wdata_reg;
    rw_next      = rw_reg;
    nack_next    = nack_reg;
    sample_next  = sample_reg;
    done_next    = 1'b0;
    scl_low_next = 1'b0;
    sda_low_next = 1'b0;
    accept       = 1'b0;
    last_bit     = (bit_cnt_reg == {BIT_CNT_W{1'b1}});

    unique case (state_reg)
      ST_START: begin
        scl_low_next = (quarter_reg == Q3);
        sda_low_next = (quarter_reg == Q2) || (quarter_reg == Q3);
      end
      ST_ADDR, ST_WR_DATA: begin
        scl_low_next = (quarter_reg == Q0) || (quarter_reg == Q3);
        sda_low_next = !shift_reg[7];
      end
      ST_ACK_A, ST_ACK_W, ST_RD_DATA, ST_MNACK: begin
        scl_low_next = (quarter_reg == Q0) || (quarter_reg == Q3);
      end
      ST_STOP: begin
        scl_low_next = (quarter_reg == Q0);
        sda_low_next = (quarter_reg != Q3);
      end
      default: ;
    endcase

    if (state_reg == ST_IDLE) begin
      if (start) begin
        accept       = 1'b1;
        rw_next      = rw;
        wdata_next   = wdata;
        shift_next   = {adr, rw};
        nack_next    = 1'b0;
        quarter_next = Q0;
        bit_cnt_next = '0;
        state_next   = ST_START;
      end
    end else if (tick) begin
      quarter_next = quarter_reg + 2'd1;
      if (quarter_reg == Q2) begin
        sample_next = sda_sync_reg;
        if (state_reg == ST_RD_DATA) rx_next = {rx_reg[6:0], sda_sync_reg};
      end
      if (quarter_reg == Q3) begin
        bit_cnt_next = '0;
        unique case (state_reg)
          ST_START: state_next = ST_ADDR;
          ST_ADDR: begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
            shift_next   = {shift_reg[6:0], 1'b0};
            if (last_bit) state_next = ST_ACK_A;
          end
          ST_ACK_A: begin
            if (sample_reg) begin
              nack_next  = 1'b1;
              state_next = ST_STOP;
            end else if (rw_reg) begin
              state_next = ST_RD_DATA;
            end else begin
              shift_next = wdata_reg;
              state_next = ST_WR_DATA;
            end
          end
          ST_WR_DATA: begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
            shift_next   = {shift_reg[6:0], 1'b0};
            if (last_bit) state_next = ST_ACK_W;
          end
          ST_ACK_W: begin
            nack_next  = sample_reg;
            state_next = ST_STOP;
          end
          ST_RD_DATA: begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
            if (last_bit) begin
              rdata_next = rx_reg;
              state_next = ST_MNACK;
            end
          end
          ST_MNACK: state_next = ST_STOP;
          ST_STOP: begin
            done_next  = 1'b1;
            state_next = ST_IDLE;
          end
          default: state_next = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      quarter_reg  <= Q0;
      bit_cnt_reg  <= '0;
      shift_reg    <= 8'h00;
      rx_reg       <= 8'h00;
      rdata_reg    <= 8'h00;
      wdata_reg    <= 8'h00;
      rw_reg       <= 1'b0;
      nack_reg     <= 1'b0;
      done_reg     <= 1'b0;
      sample_reg   <= 1'b1;
      scl_low_reg  <= 1'b0;
      sda_low_reg  <= 1'b0;
      sda_meta_reg <= 1'b1;
      sda_sync_reg <= 1'b1;
    end else begin
      state_reg    <= state_next;
      quarter_reg  <= quarter_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      rx_reg       <= rx_next;
      rdata_reg    <= rdata_next;
      wdata_reg    <= wdata_next;
      rw_reg       <= rw_next;
      nack_reg     <= nack_next;
      done_reg     <= done_next;
      sample_reg   <= sample_next;
      scl_low_reg  <= scl_low_next;
      sda_low_reg  <= sda_low_next;
      sda_meta_reg <= SDA;
      sda_sync_reg <= sda_meta_reg;
    end
  end

endmodule

// File: doc/i2c_master_byte.md
Name: i2c_master_byte

Overview:
Single-byte I2C bus master that runs one complete transaction to a 7-bit slave address, either a write of one byte or a read of one byte. It is the initiator for the existing I2CslaveWith8bitsIO IO extender, so the executor logic can set and read back extender outputs from the system clock domain. It drives open-drain SCL and SDA and supports no clock stretching, because the slave never stretches.

Parameters:
CLK_DIV, 16, clk cycles per SCL quarter-period; legal range 4..65535 (SCL freq = f_clk / (4*CLK_DIV)).

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle request; sampled only while idle
rw  in  1  0 = write, 1 = read; captured with start
adr  in  7  slave address; captured with start
wdata  in  8  write byte; captured with start
rdata  out  8  read byte; valid from the done pulse until the next accepted start
busy  out  1  transaction in progress
done  out  1  one-cycle pulse at the end of a transaction
nack  out  1  slave failed to ACK the address or the write data; valid with done, held until the next start
SCL  out  1  open drain: driven 0 or z
SDA  inout  1  open drain: driven 0 or z

Behaviour:
- Reset: busy=0, done=0, nack=0, rdata=8'h00, SCL=z, SDA=z, FSM in IDLE, prescaler cleared. Reset in mid-transaction aborts at once; both lines are released on the next clk edge and no STOP is generated.
- Quarter tick: a prescaler counts 0..CLK_DIV-1 and emits a one-cycle tick at CLK_DIV-1. The prescaler runs only when not IDLE and restarts at 0 when a start is accepted.
- Input SDA passes through a 2-FF synchroniser. SDA is sampled in the last clk cycle of quarter 2 of a bit.
- Start acceptance: start=1 in IDLE captures rw, adr and wdata, clears nack, and sets busy on the next edge. start while busy is ignored.
- Each data or ACK bit takes 4 quarters:
  - q0: SCL low, SDA set up
  - q1: SCL released
  - q2: SCL high, sample SDA
  - q3: SCL low
- FSM states:
  - IDLE
  - START: q0/q1 both lines released; q2 SDA low; q3 SCL low
  - ADDR: 8 bits, {adr, rw}, MSB first
  - ACK_A: SDA released, sample
  - WR_DATA: 8 bits of wdata, MSB first
  - ACK_W
  - RD_DATA: SDA released, 8 bits shifted into rdata MSB first
  - MNACK: master leaves SDA released, which sends NACK after the single byte
  - STOP: q0 SCL low, SDA low; q1 SCL released; q2 hold; q3 SDA released
- Transitions:
  - IDLE -> START on an accepted start
  - START -> ADDR
  - ADDR -> ACK_A
  - ACK_A: sampled 1 sets nack=1 and goes to STOP; sampled 0 goes to WR_DATA (rw=0) or RD_DATA (rw=1)
  - WR_DATA -> ACK_W
  - ACK_W -> STOP; a sampled 1 sets nack=1
  - RD_DATA -> MNACK -> STOP
  - STOP -> IDLE with done=1 and busy=0 in the same cycle
- Latency from the start edge to the done pulse:
  - full transaction: 80*CLK_DIV cycles (START 4 + ADDR 32 + ACK 4 + DATA 32 + ACK/MNACK 4 + STOP 4 quarters)
  - address NACK: 44*CLK_DIV cycles
- A data bit may change only while SCL is low. SDA transitions while SCL is high occur only in START and STOP.
- rdata updates only at the end of RD_DATA and holds through a write transaction.

Decomposition:
- Shared package i2c_master_pkg holds:
  - FSM state encoding
  - quarter-phase constants Q0..Q3
  - bit-count width
  - the CLK_DIV minimum check constant
- One natural sub-module: i2c_quarter_tick (prescaler with enable and restart producing the tick). The FSM, shift register and open-drain drivers stay in i2c_master_byte.

Test Plan:
- CLK_DIV=4, I2CslaveWith8bitsIO at ADR=7'h27 with pull-ups on SCL and SDA. Write 8'hA5 to 7'h27 -> slave IOout=8'hA5; done exactly 320 cycles after start; nack=0.
- Following read from 7'h27 -> rdata=8'hA5; nack=0; SDA released during MNACK; slave releases SDA before STOP.
- Write 8'h3C to 7'h26 -> nack=1; done at 176 cycles; slave IOout unchanged at 8'hA5.
- start pulsed again at cycle 50 of a busy transaction -> ignored; exactly one done pulse; captured adr and wdata unchanged.
- reset asserted during ADDR bit 3 -> next edge SCL=z, SDA=z, busy=0, nack=0. A subsequent write of 8'h0F -> IOout=8'h0F.
- Line monitor across all tests: SDA never changes while SCL is high except at START (falling) and STOP (rising) -> zero violations.
